bran_pred_param: RTL and testbench
==================================

# bran_pred_param

Parametrised branch predictor for the pipelined MIPS datapath. It combines a direct-mapped branch target buffer with saturating direction counters and an optional global-history (gshare) index mode. Fetch queries it combinationally every cycle with the current PC. The execute stage trains it once a branch resolves. It supersedes the fixed-size, 1-bit-state predictor and adds configurable counter width, table depth and history-indexed operation.

## Interface
- ADDR_W, 30: word-address width; the PC without its 2 LSBs.
- ENTRIES, 16: BTB/counter table depth; must be a power of 2, ≥2. IDX_W = clog2(ENTRIES).
- CTR_BITS, 2: direction-counter width, 1..4.
- HIST_BITS, 0: global-history length. 0 selects bimodal mode; 1..IDX_W selects gshare mode.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- lkp_addr  in  ADDR_W  fetch word address (imemaddr[31:2]).
- lkp_hit  out  1  a valid entry's tag matches lkp_addr.
- lkp_take  out  1  lkp_hit & counter MSB.
- lkp_target  out  ADDR_W  stored target word address.
- lkp_hist  out  max(HIST_BITS,1)  history snapshot; the pipeline carries it to EX. Reads 0 when HIST_BITS=0.
- upd_en  in  1  a resolved conditional branch is in EX this cycle; must be qualified by the pipeline enable.
- upd_addr  in  ADDR_W  word address of the resolved branch.
- upd_hist  in  max(HIST_BITS,1)  lkp_hist value carried with that branch.
- upd_taken  in  1  actual branch outcome.
- upd_target  in  ADDR_W  computed taken-target word address.

## Operation
- Index:
  - idx = addr[IDX_W-1:0] XOR zero-extended hist in gshare mode.
  - idx = addr[IDX_W-1:0] in bimodal mode.
  - Lookup uses the live history register. Update uses upd_hist.
- Tag: addr[ADDR_W-1:IDX_W].
- Entry state: valid, tag, target, ctr[CTR_BITS-1:0].
- Lookup: purely combinational. lkp_take is 0 whenever lkp_hit is 0.
- Update when upd_en=1:
  - Tag match at the indexed entry:
    - ctr saturating increment if taken, saturating decrement if not taken.
    - target overwritten only when taken.
  - No match and taken:
    - allocate or replace the entry: valid=1, new tag, target=upd_target.
    - ctr = WT (weakly taken).
  - No match and not taken: the entry is unchanged (no allocation).
  - History register: hist <= {hist[HIST_BITS-2:0], upd_taken} on every upd_en. Behaviour is non-speculative, so no recovery is needed.
- Counter constants:
  - WT = 2^(CTR_BITS-1).
  - WN = WT-1.
  - Saturation limits are 0 and 2^CTR_BITS-1.
  - For CTR_BITS=1: WT=1, WN=0.

## Timing
- Lookup latency: 0 cycles (same-cycle combinational).
- Update latency: 1 cycle. The new state is visible to lookups from the cycle after the edge on which upd_en is sampled.
- Simultaneous lookup and update of the same index: the lookup returns pre-update contents. No bypass.
- Reset values (RST high at an edge):
  - all valid=0, all ctr=WN, all tag/target=0, hist=0.
  - Outputs then read lkp_hit=0, lkp_take=0, lkp_target=0, lkp_hist=0.
- RST asserted together with upd_en: reset wins and the update is dropped.
- upd_en low: no state changes. This holds across pipeline stalls.

## Structure
- Package bran_pred_pkg holds the following; the datapath imports it:
  - the entry struct btb_entry_t (valid, tag, target, ctr);
  - the WT/WN computation functions;
  - a typedef for the history type.
- Sub-module sat_counter (parameter CTR_BITS) implements the pure next-value function: inputs ctr, inc; output ctr_nxt. It is instantiated once on the update path.
- The table is one flip-flop array of btb_entry_t. No SRAM macro.

## Test plan
- Reset: after RST, lkp_addr=0x100 → lkp_hit=0, lkp_take=0, lkp_target=0.
- Allocate and train (bimodal, CTR_BITS=2):
  - upd addr=0x100, taken=1, target=0x140 → next cycle lookup 0x100 gives hit=1, take=1, target=0x140.
  - Two further not-taken updates → take=0, and the ctr is saturated at 0 after a third.
- No allocation: not-taken update to 0x200 on an empty table → lookup 0x200 gives hit=0.
- Alias and replace (ENTRIES=16):
  - 0x100 is allocated taken; a taken update to 0x110 (same idx, different tag) → 0x100 misses and 0x110 hits with the new target.
- Same-cycle read/write: lookup and first taken update of 0x300 in the same cycle → that cycle hit=0; the next cycle hit=1.
- Gshare (HIST_BITS=4):
  - After outcomes 1,0,1,1, lkp_hist=4'b1011.
  - A branch at 0x005 allocated with upd_hist=4'b1011 lands at idx 0xE.
  - A lookup of 0x005 with history 0000 misses.
- RST mid-training clears all entries and hist.

Source files
------------

// File: rtl/bran_pred_pkg.sv
// Shared types and counter constants for the branch predictor.
package bran_pred_pkg;

    // Field widths are sized for the largest supported configuration.
    // Narrower instances zero-extend into these fields.
    localparam int MAX_ADDR_W    = 30;
    localparam int MAX_CTR_BITS  = 4;
    localparam int MAX_HIST_BITS = 8;

    typedef struct packed {
        logic                    valid;
        logic [MAX_ADDR_W-1:0]   tag;
        logic [MAX_ADDR_W-1:0]   target;
        logic [MAX_CTR_BITS-1:0] ctr;
    } btb_entry_t;

    typedef logic [MAX_HIST_BITS-1:0] hist_t;

    // Weakly-taken value: the MSB alone set.
    function automatic logic [MAX_CTR_BITS-1:0] ctr_wt(input int bits);
        return MAX_CTR_BITS'(1) << (bits - 1);
    endfunction

    // Weakly-not-taken value: one below weakly-taken.
    function automatic logic [MAX_CTR_BITS-1:0] ctr_wn(input int bits);
        return ctr_wt(bits) - MAX_CTR_BITS'(1);
    endfunction

endpackage

// File: rtl/bran_pred_param_sat_counter.sv
// Saturating up/down next-value function for a direction counter.
module sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                inc,
    output logic [CTR_BITS-1:0] ctr_nxt
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    // Step toward the outcome, holding at either limit.
    always_comb begin
        ctr_nxt = ctr;
        if (inc) begin
            if (ctr != CTR_MAX) ctr_nxt = ctr + CTR_BITS'(1);
        end else begin
            if (ctr != '0) ctr_nxt = ctr - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/bran_pred_param.sv
// Direct-mapped BTB with saturating direction counters and optional
// gshare indexing. Lookup is combinational; training is one update
// per resolved branch, applied on the following clock edge.
module bran_pred_param
    import bran_pred_pkg::*;
#(
    parameter int ADDR_W    = 30,
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = 0
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [ADDR_W-1:0]                      lkp_addr,
    output logic                                   lkp_hit,
    output logic                                   lkp_take,
    output logic [ADDR_W-1:0]                      lkp_target,
    output logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] lkp_hist,
    input  logic                                   upd_en,
    input  logic [ADDR_W-1:0]                      upd_addr,
    input  logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] upd_hist,
    input  logic                                   upd_taken,
    input  logic [ADDR_W-1:0]                      upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int HW    = (HIST_BITS > 0) ? HIST_BITS : 1;

    btb_entry_t              tbl_q [ENTRIES];
    logic [HW-1:0]           hist_q;
    logic [IDX_W-1:0]        lkp_idx;
    logic [IDX_W-1:0]        upd_idx;
    logic [MAX_ADDR_W-1:0]   lkp_tag;
    logic [MAX_ADDR_W-1:0]   upd_tag;
    btb_entry_t              lkp_e;
    btb_entry_t              upd_e;
    logic                    upd_match;
    logic [CTR_BITS-1:0]     ctr_nxt;

    generate
        if (HIST_BITS > 0) begin : g_gshare
            assign lkp_idx = lkp_addr[IDX_W-1:0] ^ IDX_W'(hist_q);
            assign upd_idx = upd_addr[IDX_W-1:0] ^ IDX_W'(upd_hist);

            if (HW == 1) begin : g_h1
                // Single-bit history simply records the last outcome.
                always_ff @(posedge CLK) begin
                    if (RST)         hist_q <= '0;
                    else if (upd_en) hist_q <= upd_taken;
                end
            end else begin : g_hn
                // Shift each resolved outcome into the global history.
                always_ff @(posedge CLK) begin
                    if (RST)         hist_q <= '0;
                    else if (upd_en) hist_q <= {hist_q[HW-2:0], upd_taken};
                end
            end
        end else begin : g_bimodal
            logic unused_hist;
            assign lkp_idx     = lkp_addr[IDX_W-1:0];
            assign upd_idx     = upd_addr[IDX_W-1:0];
            assign hist_q      = '0;
            assign unused_hist = ^upd_hist;
        end
    endgenerate

    assign lkp_tag = MAX_ADDR_W'(lkp_addr[ADDR_W-1:IDX_W]);
    assign upd_tag = MAX_ADDR_W'(upd_addr[ADDR_W-1:IDX_W]);

    // Lookup path: read the indexed entry as it stands before any update.
    always_comb begin
        lkp_e      = tbl_q[lkp_idx];
        lkp_hit    = lkp_e.valid && (lkp_e.tag == lkp_tag);
        lkp_take   = lkp_hit && lkp_e.ctr[CTR_BITS-1];
        lkp_target = lkp_e.target[ADDR_W-1:0];
        lkp_hist   = hist_q;
    end

    // Update path: find whether the resolving branch owns its slot.
    always_comb begin
        upd_e     = tbl_q[upd_idx];
        upd_match = upd_e.valid && (upd_e.tag == upd_tag);
    end

    sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat (
        .ctr     (upd_e.ctr[CTR_BITS-1:0]),
        .inc     (upd_taken),
        .ctr_nxt (ctr_nxt)
    );

    // Train the table: bump a matching entry, or allocate on a taken miss.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0,
                              ctr: ctr_wn(CTR_BITS)};
            end
        end else if (upd_en) begin
            if (upd_match) begin
                tbl_q[upd_idx].ctr <= MAX_CTR_BITS'(ctr_nxt);
                if (upd_taken) tbl_q[upd_idx].target <= MAX_ADDR_W'(upd_target);
            end else if (upd_taken) begin
                tbl_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag,
                                    target: MAX_ADDR_W'(upd_target),
                                    ctr: ctr_wt(CTR_BITS)};
            end
        end
    end

endmodule

// File: tb/tb_bran_pred_param.sv
// Directed bench for the branch predictor: a bimodal and a gshare
// instance share stimulus; each check targets the instance it describes.
module tb_bran_pred_param;

    localparam int AW = 30;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] lkp_addr;
    logic          upd_en;
    logic [AW-1:0] upd_addr;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_hist_b;
    logic [3:0]    upd_hist_g;

    logic          hit_b, take_b, hit_g, take_g;
    logic [AW-1:0] tgt_b, tgt_g;
    logic          hist_b;
    logic [3:0]    hist_g;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bran_pred_param #(.ADDR_W(AW), .ENTRIES(16), .CTR_BITS(2), .HIST_BITS(0)) dut_b (
        .CLK(CLK), .RST(RST), .lkp_addr(lkp_addr), .lkp_hit(hit_b), .lkp_take(take_b),
        .lkp_target(tgt_b), .lkp_hist(hist_b), .upd_en(upd_en), .upd_addr(upd_addr),
        .upd_hist(upd_hist_b), .upd_taken(upd_taken), .upd_target(upd_target)
    );

    bran_pred_param #(.ADDR_W(AW), .ENTRIES(16), .CTR_BITS(2), .HIST_BITS(4)) dut_g (
        .CLK(CLK), .RST(RST), .lkp_addr(lkp_addr), .lkp_hit(hit_g), .lkp_take(take_g),
        .lkp_target(tgt_g), .lkp_hist(hist_g), .upd_en(upd_en), .upd_addr(upd_addr),
        .upd_hist(upd_hist_g), .upd_taken(upd_taken), .upd_target(upd_target)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic [AW-1:0] a, input logic t,
                       input logic [AW-1:0] tg, input logic [3:0] h);
        upd_addr   = a;
        upd_taken  = t;
        upd_target = tg;
        upd_hist_g = h;
        upd_en     = 1'b1;
        tick();
        upd_en     = 1'b0;
    endtask

    task automatic look(input logic [AW-1:0] a);
        lkp_addr = a;
        #1;
    endtask

    initial begin
        RST = 1'b1; lkp_addr = '0; upd_en = 1'b0; upd_addr = '0;
        upd_taken = 1'b0; upd_target = '0; upd_hist_b = 1'b0; upd_hist_g = '0;
        tick(); tick();
        RST = 1'b0;

        // Reset state
        look(30'h100);
        chk("rst_hit", 32'(hit_b), 32'd0);
        chk("rst_take", 32'(take_b), 32'd0);
        chk("rst_target", 32'(tgt_b), 32'd0);
        chk("rst_hist_g", 32'(hist_g), 32'd0);

        // Allocate taken: counter starts weakly taken
        upd(30'h100, 1'b1, 30'h140, 4'h0);
        look(30'h100);
        chk("alloc_hit", 32'(hit_b), 32'd1);
        chk("alloc_take", 32'(take_b), 32'd1);
        chk("alloc_target", 32'(tgt_b), 32'h140);

        // Not-taken trains down; target untouched
        upd(30'h100, 1'b0, 30'h999, 4'h0);
        look(30'h100);
        chk("nt1_take", 32'(take_b), 32'd0);
        chk("nt1_hit", 32'(hit_b), 32'd1);
        chk("nt1_target", 32'(tgt_b), 32'h140);
        upd(30'h100, 1'b0, 30'h999, 4'h0);
        upd(30'h100, 1'b0, 30'h999, 4'h0);
        look(30'h100);
        chk("nt3_take", 32'(take_b), 32'd0);

        // Saturated at 0: one taken gives 1 (not taken), second gives 2
        upd(30'h100, 1'b1, 30'h140, 4'h0);
        look(30'h100);
        chk("sat0_t1_take", 32'(take_b), 32'd0);
        upd(30'h100, 1'b1, 30'h150, 4'h0);
        look(30'h100);
        chk("sat0_t2_take", 32'(take_b), 32'd1);
        chk("retarget", 32'(tgt_b), 32'h150);

        // Saturate at 3, one not-taken leaves it taken
        upd(30'h100, 1'b1, 30'h150, 4'h0);
        upd(30'h100, 1'b1, 30'h150, 4'h0);
        upd(30'h100, 1'b0, 30'h150, 4'h0);
        look(30'h100);
        chk("sat3_nt_take", 32'(take_b), 32'd1);

        // upd_en low: pending not-taken fields must have no effect
        upd_addr = 30'h100; upd_taken = 1'b0; upd_en = 1'b0;
        tick(); tick(); tick();
        look(30'h100);
        chk("stall_take", 32'(take_b), 32'd1);

        // No allocation on a not-taken miss
        upd(30'h200, 1'b0, 30'h240, 4'h0);
        look(30'h200);
        chk("noalloc_hit", 32'(hit_b), 32'd0);
        look(30'h100);
        chk("noalloc_keep", 32'(hit_b), 32'd1);

        // Alias at idx 0 replaces the older branch
        upd(30'h110, 1'b1, 30'h1A0, 4'h0);
        look(30'h100);
        chk("alias_old_hit", 32'(hit_b), 32'd0);
        look(30'h110);
        chk("alias_new_hit", 32'(hit_b), 32'd1);
        chk("alias_new_tgt", 32'(tgt_b), 32'h1A0);
        chk("alias_new_take", 32'(take_b), 32'd1);

        // Same-cycle lookup/update: no bypass
        lkp_addr = 30'h300;
        upd_addr = 30'h300; upd_taken = 1'b1; upd_target = 30'h340; upd_en = 1'b1;
        #1;
        chk("rw_same_hit", 32'(hit_b), 32'd0);
        tick();
        upd_en = 1'b0;
        #1;
        chk("rw_next_hit", 32'(hit_b), 32'd1);
        chk("rw_next_tgt", 32'(tgt_b), 32'h340);

        // Reset wins over a simultaneous update
        RST = 1'b1;
        upd_addr = 30'h123; upd_taken = 1'b1; upd_target = 30'h1; upd_en = 1'b1;
        tick();
        RST = 1'b0; upd_en = 1'b0;
        look(30'h123);
        chk("rstupd_hit", 32'(hit_b), 32'd0);
        look(30'h300);
        chk("rst_clears", 32'(hit_b), 32'd0);

        // Gshare: outcomes 1,0,1,1 build history 1011
        upd(30'h040, 1'b1, 30'h044, 4'h0);
        upd(30'h7F1, 1'b0, 30'h000, 4'h0);
        upd(30'h042, 1'b1, 30'h046, 4'h0);
        upd(30'h043, 1'b1, 30'h047, 4'h0);
        #1;
        chk("g_hist_1011", 32'(hist_g), 32'hB);
        chk("b_hist_zero", 32'(hist_b), 32'd0);

        // 0x005 with history 1011 lands at idx 0xE; history then 0111,
        // so address 0x009 (9^7=E, tag 0) reaches the same entry
        upd(30'h005, 1'b1, 30'h077, 4'hB);
        look(30'h009);
        chk("g_hist_0111", 32'(hist_g), 32'h7);
        chk("g_idxE_hit", 32'(hit_g), 32'd1);
        chk("g_idxE_tgt", 32'(tgt_g), 32'h077);

        // Drain history to 0000 with non-allocating not-taken updates
        for (int i = 0; i < 4; i++) upd(30'h7F0, 1'b0, 30'h000, 4'h0);
        look(30'h005);
        chk("g_hist_0000", 32'(hist_g), 32'd0);
        chk("g_h0_miss", 32'(hit_g), 32'd0);
        look(30'h00E);
        chk("g_h0_idxE_hit", 32'(hit_g), 32'd1);
        chk("g_h0_idxE_take", 32'(take_g), 32'd1);
        look(30'h040);
        chk("g_idx0_hit", 32'(hit_g), 32'd1);

        // Reset mid-training clears entries and history
        upd(30'h7F0, 1'b1, 30'h000, 4'h0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        look(30'h00E);
        chk("g_rst_hist", 32'(hist_g), 32'd0);
        chk("g_rst_hit", 32'(hit_g), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
